// File: rtl/fft_stream_core.sv
// Streaming N-point radix-2 DIT FFT/IFFT: bit-reversed load, one time-shared
// in-place butterfly per cycle, natural-order drain under ready/valid.
module fft_stream_core #(
    parameter int W     = 8,
    parameter int LOG2N = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [W-1:0]         in_re,
    input  logic signed [W-1:0]         in_im,
    input  logic                        inv,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [W+LOG2N:0]     out_re,
    output logic signed [W+LOG2N:0]     out_im,
    output logic [LOG2N-1:0]            out_idx,
    output logic                        out_last,
    output logic                        busy
);
    localparam int N  = 1 << LOG2N;
    localparam int OW = W + LOG2N + 1;
    localparam int PW = OW + 11;
    localparam int SW = $clog2(LOG2N);
    localparam logic signed [PW-1:0] RND = PW'(128);

    typedef enum logic [1:0] {LOAD, COMPUTE, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [LOG2N-1:0]        cnt;
    logic [SW-1:0]           stg;
    logic [LOG2N-2:0]        bfly;
    logic                    inv_q;
    logic signed [OW-1:0]    mem_re [N];
    logic signed [OW-1:0]    mem_im [N];

    logic [LOG2N-1:0]        bx, half, j_idx, top, bot;
    logic [2:0]              k16;
    logic signed [9:0]       wr, wi;
    logic signed [PW-1:0]    b_re_x, b_im_x, wr_x, wi_x;
    logic signed [OW-1:0]    a_re, a_im, t_re, t_im;
    logic signed [OW-1:0]    sum_re, sum_im, dif_re, dif_im;
    logic                    last_bfly;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    // Q1.8 twiddles for k16 = 0..7 of a 16-point circle
    function automatic logic signed [9:0] cos_q8(input logic [2:0] k);
        case (k)
            3'd0: return 10'sd256;
            3'd1: return 10'sd237;
            3'd2: return 10'sd181;
            3'd3: return 10'sd98;
            3'd4: return 10'sd0;
            3'd5: return -10'sd98;
            3'd6: return -10'sd181;
            default: return -10'sd237;
        endcase
    endfunction

    function automatic logic signed [9:0] sin_q8(input logic [2:0] k);
        case (k)
            3'd0: return 10'sd0;
            3'd1: return 10'sd98;
            3'd2: return 10'sd181;
            3'd3: return 10'sd237;
            3'd4: return 10'sd256;
            3'd5: return 10'sd237;
            3'd6: return 10'sd181;
            default: return 10'sd98;
        endcase
    endfunction

    function automatic logic signed [OW-1:0] round_q8(input logic signed [PW-1:0] acc);
        return OW'((acc + RND) >>> 8);
    endfunction

    always_comb begin
        bx     = LOG2N'(bfly);
        half   = LOG2N'(1) << stg;
        j_idx  = bx & (half - LOG2N'(1));
        top    = (((bx >> stg) << 1) << stg) | j_idx;
        bot    = top | half;
        k16    = 3'(int'(j_idx) << (3 - int'(stg)));
        wr     = cos_q8(k16);
        wi     = inv_q ? sin_q8(k16) : -sin_q8(k16);
        a_re   = mem_re[top];
        a_im   = mem_im[top];
        b_re_x = PW'(mem_re[bot]);
        b_im_x = PW'(mem_im[bot]);
        wr_x   = PW'(wr);
        wi_x   = PW'(wi);
        t_re   = round_q8(b_re_x * wr_x - b_im_x * wi_x);
        t_im   = round_q8(b_re_x * wi_x + b_im_x * wr_x);
        sum_re = a_re + t_re;
        sum_im = a_im + t_im;
        dif_re = a_re - t_re;
        dif_im = a_im - t_im;
    end

    assign last_bfly = (bfly == '1) && (stg == SW'(LOG2N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LOAD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    if (in_valid && cnt == LOG2N'(N - 1)) state_nxt = COMPUTE;
            COMPUTE: if (last_bfly) state_nxt = DRAIN;
            DRAIN:   if (out_ready && cnt == LOG2N'(N - 1)) state_nxt = LOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == DRAIN);
        busy      = (state != LOAD);
        out_idx   = (state == DRAIN) ? cnt : '0;
        out_last  = (state == DRAIN) && (cnt == LOG2N'(N - 1));
        out_re    = (state == DRAIN) ? mem_re[cnt] : '0;
        out_im    = (state == DRAIN) ? mem_im[cnt] : '0;
    end

    // cnt wraps to 0 at the end of LOAD and DRAIN, so each phase starts at index 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            stg   <= '0;
            bfly  <= '0;
            inv_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                mem_re[i] <= '0;
                mem_im[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    mem_re[bitrev(cnt)] <= OW'(in_re);
                    mem_im[bitrev(cnt)] <= OW'(in_im);
                    cnt <= cnt + 1'b1;
                    if (cnt == '0) inv_q <= inv;
                end
                COMPUTE: begin
                    mem_re[top] <= sum_re;
                    mem_im[top] <= sum_im;
                    mem_re[bot] <= dif_re;
                    mem_im[bot] <= dif_im;
                    bfly <= bfly + 1'b1;
                    if (bfly == '1) stg <= last_bfly ? '0 : stg + 1'b1;
                end
                DRAIN: if (out_ready) cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_stream_core.sv
// Bench for fft_stream_core (N=8): directed spectra plus randomized frames
// checked against an integer reference of the in-place DIT algorithm.
module tb_fft_stream_core;
    localparam int W     = 8;
    localparam int LOG2N = 3;
    localparam int N     = 1 << LOG2N;
    localparam int OW    = W + LOG2N + 1;
    localparam int LAT   = (N / 2) * LOG2N;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, in_ready, inv;
    logic signed [W-1:0]  in_re, in_im;
    logic                 out_valid, out_ready, out_last, busy;
    logic signed [OW-1:0] out_re, out_im;
    logic [LOG2N-1:0]     out_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int xr[N], xi[N], er[N], ei[N], gr[N], gi[N];
    int cos_t[8] = '{256, 237, 181, 98, 0, -98, -181, -237};
    int sin_t[8] = '{0, 98, 181, 237, 256, 237, 181, 98};

    fft_stream_core #(.W(W), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .inv(inv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int wrap_ow(input int v);
        return (v <<< (32 - OW)) >>> (32 - OW);
    endfunction

    function automatic int rev(input int v);
        int r = 0;
        for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Integer reference: bit-reversed load, then textbook in-place DIT stages
    function automatic void model_fft(input bit iv);
        int ar[N], ai[N];
        for (int n = 0; n < N; n++) begin
            ar[rev(n)] = xr[n];
            ai[rev(n)] = xi[n];
        end
        for (int s = 0; s < LOG2N; s++) begin
            int half = 1 << s;
            for (int b = 0; b < N / 2; b++) begin
                int j   = b % half;
                int top = (b / half) * 2 * half + j;
                int bot = top + half;
                int k   = j * (16 >> (s + 1));
                int c   = cos_t[k];
                int d   = iv ? sin_t[k] : -sin_t[k];
                int tr  = (ar[bot] * c - ai[bot] * d + 128) >>> 8;
                int ti  = (ar[bot] * d + ai[bot] * c + 128) >>> 8;
                int pr  = ar[top];
                int pi  = ai[top];
                ar[top] = wrap_ow(pr + tr);
                ai[top] = wrap_ow(pi + ti);
                ar[bot] = wrap_ow(pr - tr);
                ai[bot] = wrap_ow(pi - ti);
            end
        end
        for (int n = 0; n < N; n++) begin
            er[n] = ar[n];
            ei[n] = ai[n];
        end
    endfunction

    task automatic send_frame(input bit iv, input bit rnd);
        check_val("in_ready_at_load", in_ready, 1);
        for (int n = 0; n < N; n++) begin
            if (rnd) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    in_re    = W'($urandom);
                    inv      = ~iv;
                    @(negedge clk);
                end
            end
            in_valid = 1'b1;
            in_re    = W'(xr[n]);
            in_im    = W'(xi[n]);
            inv      = (n == 0) ? iv : (rnd ? 1'($urandom) : ~iv);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("busy_after_load", busy, 1);
        check_val("in_ready_after_load", in_ready, 0);
    endtask

    task automatic recv_frame(input int stall_at, input int stall_len, input bit rnd);
        int cycles = 0;
        while (out_valid !== 1'b1 && cycles < LAT + 20) begin
            if (rnd) begin
                in_valid = 1'($urandom);
                in_re    = W'($urandom);
                in_im    = W'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        check_val("latency", cycles, LAT);
        for (int k = 0; k < N; k++) begin
            int stalls;
            check_val("out_idx", out_idx, k);
            check_val("out_re", out_re, er[k]);
            check_val("out_im", out_im, ei[k]);
            check_val("out_last", out_last, (k == N - 1) ? 1 : 0);
            gr[k] = int'(out_re);
            gi[k] = int'(out_im);
            if (k == stall_at) stalls = stall_len;
            else if (rnd && $urandom_range(0, 3) == 0) stalls = $urandom_range(1, 3);
            else stalls = 0;
            if (stalls > 0) begin
                out_ready = 1'b0;
                for (int c = 0; c < stalls; c++) begin
                    @(negedge clk);
                    check_val("hold_idx", out_idx, k);
                    check_val("hold_re", out_re, er[k]);
                    check_val("hold_valid", out_valid, 1);
                    check_val("hold_in_ready", in_ready, 0);
                    check_val("hold_busy", busy, 1);
                end
            end
            out_ready = 1'b1;
            @(negedge clk);
        end
        check_val("end_in_ready", in_ready, 1);
        check_val("end_out_valid", out_valid, 0);
        check_val("end_busy", busy, 0);
    endtask

    task automatic run_frame(input bit iv, input int stall_at, input int stall_len, input bit rnd);
        model_fft(iv);
        send_frame(iv, rnd);
        recv_frame(stall_at, stall_len, rnd);
    endtask

    task automatic clear_x();
        for (int n = 0; n < N; n++) begin
            xr[n] = 0;
            xi[n] = 0;
        end
    endtask

    task automatic rand_x();
        for (int n = 0; n < N; n++) begin
            xr[n] = int'($urandom_range(0, 255)) - 128;
            xi[n] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; inv = 1'b0; out_ready = 1'b1;
        #12;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_re", out_re, 0);
        check_val("rst_out_im", out_im, 0);
        check_val("rst_out_idx", out_idx, 0);
        check_val("rst_out_last", out_last, 0);
        check_val("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        clear_x(); xr[0] = 100;
        run_frame(1'b0, -1, 0, 1'b0);
        for (int k = 0; k < N; k++) begin
            check_val("impulse_re", gr[k], 100);
            check_val("impulse_im", gi[k], 0);
        end

        for (int n = 0; n < N; n++) begin xr[n] = 10; xi[n] = 0; end
        run_frame(1'b0, -1, 0, 1'b0);
        check_val("dc_x0", gr[0], 80);
        check_val("dc_x3", gr[3], 0);

        for (int n = 0; n < N; n++) begin xr[n] = (n % 2 == 0) ? 50 : -50; xi[n] = 0; end
        run_frame(1'b0, -1, 0, 1'b0);
        check_val("alt_x4", gr[4], 400);
        check_val("alt_x1", gr[1], 0);

        for (int n = 0; n < N; n++) begin xr[n] = -128; xi[n] = -128; end
        run_frame(1'b0, -1, 0, 1'b0);
        check_val("fs_x0_re", gr[0], -1024);
        check_val("fs_x0_im", gi[0], -1024);
        check_val("fs_x5_re", gr[5], 0);

        clear_x(); xr[1] = 64;
        run_frame(1'b0, 3, 5, 1'b0);
        check_val("fwd_x1_re", gr[1], 45);
        check_val("fwd_x1_im", gi[1], -45);
        check_val("fwd_x2_re", gr[2], 0);
        check_val("fwd_x2_im", gi[2], -64);
        check_val("fwd_x3_re", gr[3], -45);
        check_val("fwd_x3_im", gi[3], -45);
        check_val("fwd_x4_re", gr[4], -64);
        check_val("fwd_x7_re", gr[7], 45);
        check_val("fwd_x7_im", gi[7], 45);

        run_frame(1'b1, -1, 0, 1'b0);
        check_val("inv_x1_im", gi[1], 45);
        check_val("inv_x2_im", gi[2], 64);
        check_val("inv_x3_re", gr[3], -45);
        check_val("inv_x3_im", gi[3], 45);

        // Abort in COMPUTE, then in DRAIN; each must recover cleanly
        rand_x();
        send_frame(1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("abort_c_out_valid", out_valid, 0);
        check_val("abort_c_in_ready", in_ready, 1);
        check_val("abort_c_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        clear_x(); xr[0] = 100;
        run_frame(1'b0, -1, 0, 1'b0);
        check_val("post_abort_re", gr[5], 100);

        rand_x();
        send_frame(1'b1, 1'b0);
        repeat (LAT + 2) @(negedge clk);
        check_val("pre_abort_d_valid", out_valid, 1);
        rst = 1'b0;
        #1;
        check_val("abort_d_out_valid", out_valid, 0);
        check_val("abort_d_out_re", out_re, 0);
        check_val("abort_d_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int f = 0; f < 20; f++) begin
            rand_x();
            run_frame(1'($urandom), -1, 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
